// File: rtl/arb_mux_n.sv
// arb_mux_n: registered N-to-1 stream mux with round-robin or fixed-priority arbitration
module arb_mux_n #(
  parameter int N_CH = 4,
  parameter int WIDTH = 8,
  parameter int ARB_MODE = 0,
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel
);
  logic [WIDTH-1:0] ch [N_CH];
  logic [SEL_W-1:0] ptr, win, idx;
  logic found, load;
  int s;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch[i] = in_data[i*WIDTH +: WIDTH];
  end
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    s = 0;
    for (int k = 0; k < N_CH; k++) begin
      s = (ARB_MODE != 0) ? k : int'(ptr) + k;
      idx = SEL_W'((s >= N_CH) ? s - N_CH : s);
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign load = ~out_valid | out_ready;
  assign in_ready = (load & found & ~rst) ? N_CH'(1) << win : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= found;
      if (found) begin
        out_data <= ch[win];
        out_sel  <= win;
        ptr      <= (win == SEL_W'(N_CH - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: scoreboard bench for round-robin, fixed-priority and 3-channel arb_mux_n
module tb_arb_mux_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [3:0] v0, ir0, v1, ir1;
  logic [2:0] v2, ir2;
  logic [31:0] d0, d1;
  logic [23:0] d2;
  logic or0, or1, or2, ov0, ov1, ov2;
  logic [7:0] od0, od1, od2;
  logic [1:0] os0, os1, os2;
  logic [9:0] q0[$], q1[$], q2[$];
  int checks = 0, failures = 0;
  arb_mux_n #(.N_CH(4), .WIDTH(8), .ARB_MODE(0)) u0 (.clk(clk), .rst(rst), .in_valid(v0), .in_ready(ir0),
    .in_data(d0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_sel(os0));
  arb_mux_n #(.N_CH(4), .WIDTH(8), .ARB_MODE(1)) u1 (.clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1),
    .in_data(d1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sel(os1));
  arb_mux_n #(.N_CH(3), .WIDTH(8), .ARB_MODE(0)) u2 (.clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2),
    .in_data(d2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_sel(os2));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst && ov0 && or0) begin
      if (q0.size() == 0) chk("u0_extra_word", {os0, od0}, 32'hdead);
      else chk("u0_out", {os0, od0}, q0.pop_front());
    end
    if (!rst && ov1 && or1) begin
      if (q1.size() == 0) chk("u1_extra_word", {os1, od1}, 32'hdead);
      else chk("u1_out", {os1, od1}, q1.pop_front());
    end
    if (!rst && ov2 && or2) begin
      if (q2.size() == 0) chk("u2_extra_word", {os2, od2}, 32'hdead);
      else chk("u2_out", {os2, od2}, q2.pop_front());
    end
  end
  initial begin
    rst = 1'b1;
    {v0, v1, v2} = '0;
    {d0, d1, d2} = '0;
    {or0, or1, or2} = 3'b111;
    repeat (2) step;
    chk("rst_out_valid", ov0, 0);
    chk("rst_in_ready", ir0, 0);
    rst = 1'b0;
    d0[16 +: 8] = 8'hA5;
    v0 = 4'b0100;
    #1 chk("single_in_ready", ir0, 4'b0100);
    q0.push_back({2'd2, 8'hA5});
    step;
    v0 = '0;
    #1 chk("idle_in_ready", ir0, 0);
    step;
    or0 = 1'b0;
    d0[16 +: 8] = 8'h5A;
    v0 = 4'b0100;
    step;
    v0 = '0;
    #1 chk("pre_rst_data", {ov0, od0}, {1'b1, 8'h5A});
    rst = 1'b1;
    v0 = 4'b1111;
    #1 chk("async_rst_out", {ov0, os0, od0}, 0);
    chk("async_rst_in_ready", ir0, 0);
    step;
    rst = 1'b0;
    or0 = 1'b1;
    for (int i = 0; i < 4; i++) d0[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < 6; i++) q0.push_back({2'(i % 4), 8'h10 + 8'(i % 4)});
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_in_ready", ir0, 32'(4'b0001 << (i % 4)));
      step;
    end
    or0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_hold", {ir0, os0, od0}, {4'b0000, 2'd1, 8'h11});
      step;
    end
    or0 = 1'b1;
    #1 chk("after_stall_in_ready", ir0, 4'b0100);
    q0.push_back({2'd2, 8'h12});
    step;
    v0 = '0;
    repeat (2) step;
    chk("u0_drained", ov0, 0);
    d1[8 +: 8] = 8'h21;
    d1[24 +: 8] = 8'h23;
    v1 = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fp_in_ready", ir1, 4'b0010);
      q1.push_back({2'd1, 8'h21});
      step;
    end
    v1 = 4'b1000;
    #1 chk("fp_ch3_in_ready", ir1, 4'b1000);
    q1.push_back({2'd3, 8'h23});
    step;
    v1 = '0;
    repeat (2) step;
    d2[16 +: 8] = 8'h32;
    d2[0 +: 8] = 8'h30;
    v2 = 3'b100;
    #1 chk("n3_ch2_in_ready", ir2, 3'b100);
    q2.push_back({2'd2, 8'h32});
    step;
    v2 = 3'b101;
    #1 chk("n3_wrap_in_ready", ir2, 3'b001);
    q2.push_back({2'd0, 8'h30});
    step;
    v2 = 3'b100;
    #1 chk("n3_next_in_ready", ir2, 3'b100);
    q2.push_back({2'd2, 8'h32});
    step;
    v2 = '0;
    repeat (3) step;
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
